// File: rtl/wb_ram_pipelined_if.sv
// Wishbone B4 pipelined bus bundle for wb_ram_pipelined.
// Signal names follow the slave's point of view.
interface wb_ram_pipelined_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 20
);
   logic                    cyc_i;
   logic                    stb_i;
   logic                    we_i;
   logic [ADDR_WIDTH-1:0]   adr_i;
   logic [DATA_WIDTH/8-1:0] sel_i;
   logic [DATA_WIDTH-1:0]   dat_i;
   logic [DATA_WIDTH-1:0]   dat_o;
   logic                    ack_o;
   logic                    err_o;
   logic                    stall_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      output dat_o, ack_o, err_o, stall_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      input  dat_o, ack_o, err_o, stall_o
   );
endinterface

// File: rtl/wb_ram_pipelined.sv
// Wishbone B4 pipelined single-port RAM: one request per cycle, in-order responses after LATENCY.
// Define WB_RAM_CLEAR_EN to zero every word after reset (requests stall until the walk completes).
module wb_ram_pipelined #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter string       INIT_FILE  = "none"
) (
   input logic               clk_i,
   input logic               rst_i,
   wb_ram_pipelined_if.slave bus
);
   localparam int unsigned SelW  = DATA_WIDTH / 8;
   localparam int unsigned OffW  = $clog2(SelW);
   localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
   localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IdxW-1:0]  idx;
   logic [MemAw-1:0] mem_idx;
   logic             in_range;
   logic             stall;
   logic             accept;
   logic             wr_en;
   logic             rd_en;
   logic             clr_we;
   logic [MemAw-1:0] clr_idx;

   assign idx      = bus.adr_i[ADDR_WIDTH-1:OffW];
   assign mem_idx  = idx[MemAw-1:0];
   assign in_range = 32'(idx) < DEPTH;

   if (OffW > 0) begin : g_unused_off
      logic unused_adr_off;
      assign unused_adr_off = ^bus.adr_i[OffW-1:0];
   end

   // Requests presented while reset is held are ignored so reset never disturbs memory.
   assign accept = bus.cyc_i & bus.stb_i & ~stall & rst_i;
   assign wr_en  = accept & bus.we_i & in_range;
   assign rd_en  = accept & ~bus.we_i & in_range;

`ifdef WB_RAM_CLEAR_EN
   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e           state_q, state_d;
   logic [MemAw-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      stall     = 1'b0;
      clr_we    = 1'b0;
      unique case (state_q)
         StClear: begin
            stall  = 1'b1;
            clr_we = rst_i;
            if (clr_cnt_q == MemAw'(DEPTH - 1)) begin
               state_d = StRun;
            end else begin
               clr_cnt_d = clr_cnt_q + MemAw'(1);
            end
         end
         StRun: begin
            stall = 1'b0;
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   assign clr_idx = clr_cnt_q;
`else
   assign stall   = 1'b0;
   assign clr_we  = 1'b0;
   assign clr_idx = '0;
`endif

   // Response pipeline: stage LATENCY-1 drives the bus.
   logic [LATENCY-1:0]    vld_q;
   logic [LATENCY-1:0]    err_q;
   logic [LATENCY-1:0]    rd_q;
   logic [DATA_WIDTH-1:0] rdat_q [LATENCY];
   logic [DATA_WIDTH-1:0] dat_hold_q;
   logic [DATA_WIDTH-1:0] dat_out;
   logic                  ack;
   logic                  err;

   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < SelW; i++) begin
            if (bus.sel_i[i]) begin
               mem[mem_idx][8*i +: 8] <= bus.dat_i[8*i +: 8];
            end
         end
      end
      if (rd_en) begin
         rdat_q[0] <= mem[mem_idx];
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
         rdat_q[i] <= rdat_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_q      <= '0;
         err_q      <= '0;
         rd_q       <= '0;
         dat_hold_q <= '0;
      end else begin
         vld_q[0] <= accept;
         err_q[0] <= ~in_range;
         rd_q[0]  <= ~bus.we_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            rd_q[i]  <= rd_q[i-1];
         end
         // Dropping cyc_i abandons everything in flight.
         if (!bus.cyc_i) begin
            vld_q <= '0;
         end
         dat_hold_q <= dat_out;
      end
   end

   // Gating with cyc_i keeps a response from surfacing in the abort cycle itself.
   assign ack     = vld_q[LATENCY-1] & ~err_q[LATENCY-1] & bus.cyc_i;
   assign err     = vld_q[LATENCY-1] & err_q[LATENCY-1] & bus.cyc_i;
   assign dat_out = (ack & rd_q[LATENCY-1]) ? rdat_q[LATENCY-1] : dat_hold_q;

   assign bus.ack_o   = ack;
   assign bus.err_o   = err;
   assign bus.dat_o   = dat_out;
   assign bus.stall_o = stall;

endmodule

// File: tb/tb_wb_ram_pipelined.sv
// Randomised bench for wb_ram_pipelined against a cycle-level transaction model.
// Honours WB_RAM_CLEAR_EN when the design is built with it.
module tb_wb_ram_pipelined;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 20;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned DEPTH = 1000;
   localparam int unsigned LAT   = 2;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   always #5 clk_i = ~clk_i;

   wb_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   wb_ram_pipelined #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DEPTH),
      .LATENCY   (LAT),
      .INIT_FILE ("none")
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   typedef struct {
      int unsigned   due;
      bit            err;
      bit            rd;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         pend[$];
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] hold;
   int unsigned   clear_left;
   int unsigned   cyc_n;
   int unsigned   n_tests;
   int unsigned   n_fail;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc_n, got, exp);
      end
   endtask

   // One bus cycle: drive, compare outputs against the model, then advance the model.
   task automatic run_cycle(input bit rst, input bit cyc, input bit stb, input bit we,
                            input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                            input logic [DW-1:0] dat);
      bit            e_ack, e_err, e_stall, inr;
      logic [DW-1:0] e_dat;
      int unsigned   idx;
      resp_t         r;
      rst_i     = rst;
      bus.cyc_i = cyc;
      bus.stb_i = stb;
      bus.we_i  = we;
      bus.adr_i = adr;
      bus.sel_i = sel;
      bus.dat_i = dat;
      @(negedge clk_i);
      if (!cyc) pend.delete();
      e_ack   = 1'b0;
      e_err   = 1'b0;
      e_dat   = hold;
      e_stall = clear_left > 0;
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
         if (pend[0].err) begin
            e_err = 1'b1;
         end else begin
            e_ack = 1'b1;
            if (pend[0].rd) e_dat = pend[0].data;
         end
      end
      check("ack", DW'(bus.ack_o), DW'(e_ack));
      check("err", DW'(bus.err_o), DW'(e_err));
      check("stall", DW'(bus.stall_o), DW'(e_stall));
      check("dat", bus.dat_o, e_dat);
      if (!rst) begin
         pend.delete();
         hold = '0;
`ifdef WB_RAM_CLEAR_EN
         clear_left = DEPTH;
         for (int unsigned w = 0; w < DEPTH; w++) model_mem[w] = '0;
`endif
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc_n) void'(pend.pop_front());
         if (cyc && stb && !e_stall) begin
            idx    = 32'(adr[AW-1:2]);
            inr    = idx < DEPTH;
            r.due  = cyc_n + LAT;
            r.err  = !inr;
            r.rd   = !we;
            r.data = '0;
            if (inr) r.data = model_mem[idx];
            pend.push_back(r);
            if (we && inr) begin
               for (int unsigned b = 0; b < SW; b++) begin
                  if (sel[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
               end
            end
         end
         if (clear_left > 0) clear_left--;
         hold = e_dat;
      end
      cyc_n++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] adr, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, adr, sel, dat);
   endtask

   task automatic rd(input logic [AW-1:0] adr);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, adr, '0, $urandom);
   endtask

   task automatic wait_clear();
      for (int i = 0; i < int'(DEPTH) + 2 && clear_left > 0; i++) idle();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      cyc_n      = 0;
      hold       = '0;
`ifdef WB_RAM_CLEAR_EN
      clear_left = DEPTH;
      for (int unsigned w = 0; w < DEPTH; w++) model_mem[w] = '0;
`else
      clear_left = 0;
`endif
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.adr_i = '0;
      bus.sel_i = '0;
      bus.dat_i = '0;
      @(posedge clk_i);
      #1;
      repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      wait_clear();

`ifdef WB_RAM_CLEAR_EN
      for (int unsigned w = 0; w < 16; w++) rd(AW'(w * 4));
      repeat (3) idle();
`endif

      // Give every word a known value.
      for (int unsigned w = 0; w < DEPTH; w++) wr(AW'(w * 4), 4'hF, $urandom);
      repeat (3) idle();

      wr(20'h10, 4'hF, 32'hDEADBEEF);
      rd(20'h10);
      repeat (3) idle();
      check("full_word_hold", bus.dat_o, 32'hDEADBEEF);

      wr(20'h20, 4'hF, 32'hAAAAAAAA);
      wr(20'h20, 4'b0101, 32'h11223344);
      rd(20'h20);
      repeat (3) idle();
      check("byte_lane_hold", bus.dat_o, 32'hAA22AA44);

      for (int unsigned w = 0; w < 8; w++) rd(AW'(w * 4));
      repeat (3) idle();

      wr(20'hFA0, 4'hF, 32'h12345678);
      rd(20'hFA0);
      rd(20'hF9C);
      rd(20'h0);
      repeat (3) idle();

      rd(20'h0);
      rd(20'h4);
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) idle();
      rd(20'h8);
      repeat (3) idle();

      rd(20'h10);
      rd(20'h14);
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      wait_clear();
      rd(20'h10);
      repeat (3) idle();

      for (int n = 0; n < 3000; n++) begin
         bit            r_rst, r_cyc, r_stb, r_we;
         int unsigned   word;
         logic [1:0]    off;
         logic [AW-1:0] adr;
         r_rst = $urandom_range(0, 499) != 0;
         r_cyc = $urandom_range(0, 15) != 0;
         r_stb = $urandom_range(0, 3) != 0;
         r_we  = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 15) == 0) word = $urandom_range(DEPTH, (1 << (AW - 2)) - 1);
         else                            word = $urandom_range(0, DEPTH - 1);
         off = 2'($urandom_range(0, 3));
         adr = {word[AW-3:0], off};
         run_cycle(r_rst, r_cyc, r_stb, r_we, adr, 4'($urandom), $urandom);
      end
      repeat (4) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
